// File: rtl/uart_rx_framer_pkg.sv
// rtl/uart_rx_framer_pkg.sv - shared constants and FSM encoding for the UART receive framer
package uart_rx_framer_pkg;

  localparam int DATA_W           = 8;
  localparam int CLKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_framer_sync_2ff.sv
// rtl/uart_rx_framer_sync_2ff.sv - two-flop synchronizer with parameterized reset value
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_framer.sv
// rtl/uart_rx_framer.sv - 8N1 UART receiver with valid/ready output and error pulses
module uart_rx_framer
  import uart_rx_framer_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic              rx_s;
  rx_state_e         state;
  logic [CW-1:0]     clk_cnt;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] shreg;

  logic at_last;
  logic stop_hit;
  logic deliver;
  logic bad_stop;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign at_last  = (clk_cnt == CNT_LAST);
  assign stop_hit = (state == ST_STOP) && at_last;
  assign deliver  = stop_hit && rx_s;
  assign bad_stop = stop_hit && !rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          clk_cnt <= '0;
          if (!rx_s) state <= ST_START;
        end
        // Mid-start-bit resample rejects short glitches on the line.
        ST_START: begin
          if (clk_cnt == CNT_HALF) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            state   <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (at_last) begin
            clk_cnt        <= '0;
            shreg[bit_cnt] <= rx_s;
            if (bit_cnt == 3'd7) state <= ST_STOP;
            else                 bit_cnt <= bit_cnt + 3'd1;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (at_last) begin
            clk_cnt <= '0;
            state   <= rx_s ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        ST_WAIT_HIGH: begin
          clk_cnt <= '0;
          if (rx_s) state <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          clk_cnt <= '0;
        end
      endcase
    end
  end

  // A delivery landing on a handshake reloads in place; otherwise a full buffer drops the byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= 1'b0;
      if (deliver) begin
        if (!valid || ready) begin
          data  <= shreg;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit (legal range 4..4096, even).
REQ-002 SHALL have port clk  input  1  the single system clock; all logic is rising-edge clocked.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port data  output  8  received byte, LSB first on the line.
REQ-006 SHALL have port valid  output  1  data holds an unconsumed byte.
REQ-007 SHALL have port ready  input  1  consumer accepts data when valid&&ready.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse: a completed byte was dropped.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; rx_s denotes the synchronizer output, and only rx_s is used downstream.
REQ-011 SHALL implement the FSM states IDLE, START, DATA, STOP and WAIT_HIGH, with one bit counter (0..7) and one clock counter (0..CLKS_PER_BIT-1).
REQ-012 IDLE: when rx_s=0, SHALL go to START with the clock counter cleared.
REQ-013 START: at clock count CLKS_PER_BIT/2-1, SHALL resample rx_s; if 0, go to DATA with counters cleared; if 1, treat as a glitch and return to IDLE with no output.
REQ-014 DATA: at every clock count CLKS_PER_BIT-1, SHALL sample rx_s into shift-register position bit_cnt (LSB first); after bit 7, go to STOP.
REQ-015 STOP: at clock count CLKS_PER_BIT-1, SHALL sample rx_s; if 1, deliver the byte (REQ-017) and go to IDLE; if 0, pulse frame_err, discard the byte, and go to WAIT_HIGH.
REQ-016 WAIT_HIGH: SHALL stay until rx_s=1, then go to IDLE; a break condition therefore yields exactly one frame_err.
REQ-017 Delivery: data and valid SHALL update on the clock edge after the stop sample; the stop sample occurs 9*CLKS_PER_BIT+CLKS_PER_BIT/2 cycles after the first cycle in which rx_s=0 (152 cycles for the default).
REQ-018 valid SHALL stay high, with data stable, until a cycle in which ready=1; it falls after that edge unless REQ-019 applies.
REQ-019 If a delivery coincides with valid&&ready, SHALL load the new byte and keep valid=1, with no overrun.
REQ-020 If a delivery occurs while valid=1 and ready=0, SHALL keep the old data, drop the new byte, and pulse overrun for one cycle.
REQ-021 ready SHALL be ignored while valid=0; rx activity SHALL never stall on ready.
REQ-022 frame_err and overrun SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-023 On rst_n=0, SHALL asynchronously set: both synchronizer flops to 1, state=IDLE, both counters=0, shift register=0, data=8'h00, valid=0, frame_err=0, overrun=0.
REQ-024 Reset mid-frame SHALL abandon the frame; after release, reception resumes at the next falling edge seen on rx_s, even if the line is still low (behaves as a new start).

Structure
REQ-025 A shared package SHALL hold the FSM state enum, the data width constant (8), and the default CLKS_PER_BIT value.
REQ-026 The 2-flop synchronizer SHALL be a separate sub-module named sync_2ff (reset value parameterized; 1 here).
REQ-027 The byte assembly SHALL be internal to this block.

Verification
REQ-028 Frame 8'hA5 with valid stop, ready held 1 -> data=8'hA5, valid high exactly 1 cycle, frame_err=0, overrun=0.
REQ-029 rx low for CLKS_PER_BIT/2-2 cycles, then high -> FSM returns to IDLE; no valid, no frame_err.
REQ-030 Frame 8'h3C with stop bit low, line then high -> single frame_err pulse, valid stays 0; the next frame 8'h5A is then received correctly.
REQ-031 ready=0, frames 8'h11 then 8'h22 -> data=8'h11, valid=1, one overrun pulse at the second delivery; raising ready consumes 8'h11.
REQ-032 ready rises in the same cycle as the second delivery -> 8'h11 consumed, data=8'h22, valid stays 1, overrun=0.
REQ-033 rst_n pulsed low during DATA bit 4 -> all outputs return to reset values immediately; the following frame 8'hC3 is received correctly.
